// File: rtl/mem_stage_pipelined.sv
// mem_stage_pipelined: MIPS MEM stage with internal byte-lane data memory,
// a MEM/WB pipeline register and a branch-resolution output.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the data memory (power of two)
//   ADDR_W       word-address width, log2(DEPTH_WORDS)
//   WAIT_CYCLES  extra cycles per load/store (0..15)
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   -> misaligned half/word accesses are trapped (write suppressed,
//                load data zeroed, reg_write dropped, misalign flag raised)
//   undefined -> low address bits are ignored to force alignment, misalign = 0
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid            EX/MEM holds a valid instruction
//   mem_read/mem_write  load / store (both set = store only)
//   branch, alu_zero    branch resolution inputs
//   reg_write,
//   mem_to_reg          control passed through to WB
//   size                00 byte, 01 half, 1x word
//   load_unsigned       zero-extend (1) or sign-extend (0) loads
//   alu_result          byte address / ALU value
//   write_data          store data
//   write_reg           destination register
//   stall_out           hold EX/MEM and earlier stages
//   pc_src              branch taken (combinational, one cycle)
//   misalign            registered misalignment flag
//   wb_*                MEM/WB register outputs

// One byte lane of the data memory: asynchronous read, clocked write.
module mem_lane #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

module mem_stage_pipelined #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg,
  output logic        stall_out,
  output logic        pc_src,
  output logic        misalign,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_write_reg
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] WC        = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;

  logic        w_memop, w_stall, w_accept, w_mis, w_we, w_is_load;
  logic        w_sz_byte, w_sz_half;
  logic [1:0]  w_boff;
  logic [ADDR_W-1:0] w_widx;
  logic [NUM_LANES-1:0]        w_lane_en;
  logic [NUM_LANES-1:0][7:0]   w_lane_wd;
  logic [NUM_LANES-1:0][7:0]   w_rlane;
  logic [31:0] w_rword, w_ext;
  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_memop   = in_valid & (mem_read | mem_write);
  assign w_accept  = in_valid & ~w_stall;
  assign stall_out = w_stall;
  assign pc_src    = w_accept & branch & alu_zero;

  assign w_widx    = alu_result[ADDR_W+1:2];
  assign w_boff    = alu_result[1:0];
  assign w_sz_byte = (size == 2'b00);
  assign w_sz_half = (size == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
  // Only memory ops can be misaligned; ALU ops with odd results are fine.
  assign w_mis = w_memop & ((w_sz_half & w_boff[0]) | (size[1] & (|w_boff)));
`else
  assign w_mis = 1'b0;
`endif

  // Reset on the access edge must not let a store through.
  assign w_we      = w_accept & mem_write & ~w_mis & ~reset;
  assign w_is_load = mem_read & ~mem_write & ~w_mis;

  // Lane enables and store data; half/word selection ignores low address
  // bits, which is what forces alignment when the check is disabled.
  always_comb begin
    w_lane_en = '0;
    w_lane_wd = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_sz_byte) begin
        w_lane_en[i] = (w_boff == 2'(i));
        w_lane_wd[i] = write_data[7:0];
      end else if (w_sz_half) begin
        w_lane_en[i] = (w_boff[1] == 1'(i >> 1));
        w_lane_wd[i] = (i % 2 == 1) ? write_data[15:8] : write_data[7:0];
      end else begin
        w_lane_en[i] = 1'b1;
        w_lane_wd[i] = write_data[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_lane #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .i_we    (w_we & w_lane_en[g]),
      .i_addr  (w_widx),
      .i_wdata (w_lane_wd[g]),
      .o_rdata (w_rlane[g])
    );
  end

  assign w_rword = w_rlane;

  // Load lane select and extension.
  always_comb begin
    w_b   = w_rlane[w_boff];
    w_h   = w_boff[1] ? w_rword[31:16] : w_rword[15:0];
    w_ext = w_rword;
    if (w_sz_byte)      w_ext = {{24{~load_unsigned & w_b[7]}}, w_b};
    else if (w_sz_half) w_ext = {{16{~load_unsigned & w_h[15]}}, w_h};
  end

  // Wait-state FSM: IDLE stalls on the first cycle of a memop, BUSY counts
  // up to WAIT_CYCLES and releases the stall on the access cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop && (WAIT_CYCLES > 0)) begin
          w_stall     = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = 4'd1;
        end
      end
      BUSY: begin
        if (r_cnt < WC) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // MEM/WB register. Bubbles and stalls drop valid and reg_write only.
  logic r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg;
  logic [31:0] r_wb_read_data, r_wb_alu_result;
  logic [4:0]  r_wb_write_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_read_data  <= '0;
      r_wb_alu_result <= '0;
      r_wb_write_reg  <= '0;
    end else if (w_accept) begin
      r_wb_valid      <= 1'b1;
      r_wb_reg_write  <= reg_write & ~w_mis;
      r_wb_mem_to_reg <= mem_to_reg;
      r_wb_read_data  <= w_is_load ? w_ext : 32'd0;
      r_wb_alu_result <= alu_result;
      r_wb_write_reg  <= write_reg;
    end else begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (reset)         r_misalign <= 1'b0;
    else if (w_accept) r_misalign <= w_mis;
  end
  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  assign wb_valid      = r_wb_valid;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_mem_to_reg = r_wb_mem_to_reg;
  assign wb_read_data  = r_wb_read_data;
  assign wb_alu_result = r_wb_alu_result;
  assign wb_write_reg  = r_wb_write_reg;
endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Bench for mem_stage_pipelined: three instances with WAIT_CYCLES 0, 2, 3.
// Instance 0 runs a directed vector table; instances 1 and 2 cover the
// wait-state stall sequence and reset during a pending access.
module tb_mem_stage_pipelined;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, in_valid, mem_read, mem_write, branch, alu_zero;
  logic [2:0] reg_write, mem_to_reg, load_unsigned;
  logic [2:0][1:0]  size;
  logic [2:0][31:0] alu_result, write_data;
  logic [2:0][4:0]  write_reg;

  logic [2:0] stall_out, pc_src, misalign, wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [2:0][31:0] wb_read_data, wb_alu_result;
  logic [2:0][4:0]  wb_write_reg;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_pipelined #(
      .DEPTH_WORDS (256),
      .ADDR_W      (8),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .clk           (clk),
      .reset         (rst[g]),
      .in_valid      (in_valid[g]),
      .mem_read      (mem_read[g]),
      .mem_write     (mem_write[g]),
      .branch        (branch[g]),
      .alu_zero      (alu_zero[g]),
      .reg_write     (reg_write[g]),
      .mem_to_reg    (mem_to_reg[g]),
      .size          (size[g]),
      .load_unsigned (load_unsigned[g]),
      .alu_result    (alu_result[g]),
      .write_data    (write_data[g]),
      .write_reg     (write_reg[g]),
      .stall_out     (stall_out[g]),
      .pc_src        (pc_src[g]),
      .misalign      (misalign[g]),
      .wb_valid      (wb_valid[g]),
      .wb_reg_write  (wb_reg_write[g]),
      .wb_mem_to_reg (wb_mem_to_reg[g]),
      .wb_read_data  (wb_read_data[g]),
      .wb_alu_result (wb_alu_result[g]),
      .wb_write_reg  (wb_write_reg[g])
    );
  end

  typedef struct {
    logic        rd, wr, br, z, rw, m2r;
    logic [1:0]  sz;
    logic        lu;
    logic [31:0] a, wd;
    logic [4:0]  wreg;
    logic        pc, mis;
    logic [31:0] exp_rd;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int rd, int wr, int br, int z, int rw, int m2r, int sz,
                              int lu, logic [31:0] a, logic [31:0] wd, int wreg,
                              int pc, int mis, logic [31:0] exp_rd);
    vec_t v;
    v.rd = 1'(rd); v.wr = 1'(wr); v.br = 1'(br); v.z = 1'(z);
    v.rw = 1'(rw); v.m2r = 1'(m2r); v.sz = 2'(sz); v.lu = 1'(lu);
    v.a = a; v.wd = wd; v.wreg = 5'(wreg);
    v.pc = 1'(pc); v.mis = 1'(mis); v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic set_in(input int k, input logic v, input vec_t x);
    in_valid[k]      = v;
    mem_read[k]      = x.rd;
    mem_write[k]     = x.wr;
    branch[k]        = x.br;
    alu_zero[k]      = x.z;
    reg_write[k]     = x.rw;
    mem_to_reg[k]    = x.m2r;
    size[k]          = x.sz;
    load_unsigned[k] = x.lu;
    alu_result[k]    = x.a;
    write_data[k]    = x.wd;
    write_reg[k]     = x.wreg;
  endtask

  // One single-cycle instruction on instance 0, full MEM/WB check.
  task automatic apply_vec(input int i, input vec_t v);
    set_in(0, 1'b1, v);
    #1;
    chk($sformatf("v%0d stall", i), 32'(stall_out[0]), 32'd0);
    chk($sformatf("v%0d pc_src", i), 32'(pc_src[0]), 32'(v.pc));
    tick();
    chk($sformatf("v%0d wb_valid", i), 32'(wb_valid[0]), 32'd1);
    chk($sformatf("v%0d rdata", i), wb_read_data[0], v.exp_rd);
    chk($sformatf("v%0d alu", i), wb_alu_result[0], v.a);
    chk($sformatf("v%0d wreg", i), 32'(wb_write_reg[0]), 32'(v.wreg));
    chk($sformatf("v%0d reg_write", i), 32'(wb_reg_write[0]), 32'(v.rw & ~v.mis));
    chk($sformatf("v%0d m2r", i), 32'(wb_mem_to_reg[0]), 32'(v.m2r));
    chk($sformatf("v%0d misalign", i), 32'(misalign[0]), 32'(v.mis));
  endtask

  // Memop held until the stall drops; checks stall length and the wb pulse.
  task automatic run_mem(input string nm, input int k, input vec_t v, input int exp_wait);
    int n;
    n = 0;
    set_in(k, 1'b1, v);
    #1;
    while (stall_out[k] && n < 40) begin
      n++;
      tick();
      chk({nm, " wb_valid during stall"}, 32'(wb_valid[k]), 32'd0);
    end
    chk({nm, " stall cycles"}, n, exp_wait);
    tick();
    chk({nm, " wb_valid"}, 32'(wb_valid[k]), 32'd1);
    chk({nm, " rdata"}, wb_read_data[k], v.exp_rd);
    in_valid[k] = 1'b0;
    tick();
    chk({nm, " wb_valid after"}, 32'(wb_valid[k]), 32'd0);
  endtask

  vec_t tbl[18];
  vec_t nop;

  initial begin
    nop = mk(0,0,0,0,0,0,0,0, 32'h0, 32'h0, 0, 0,0, 32'h0);
    rst = 3'b111;
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, nop);

    //        rd wr br z rw m2r sz lu  addr           wdata          wreg pc mis exp
    tbl[0]  = mk(0,1,0,0,0,0,2,0, 32'h10,       32'hDEADBEEF, 0, 0,0, 32'h0);
    tbl[1]  = mk(1,0,0,0,1,1,2,0, 32'h10,       32'h0,        5, 0,0, 32'hDEADBEEF);
    tbl[2]  = mk(0,1,0,0,0,0,0,0, 32'h13,       32'h12345680, 0, 0,0, 32'h0);
    tbl[3]  = mk(1,0,0,0,1,1,2,0, 32'h10,       32'h0,        6, 0,0, 32'h80ADBEEF);
    tbl[4]  = mk(1,0,0,0,1,1,0,0, 32'h13,       32'h0,        7, 0,0, 32'hFFFFFF80);
    tbl[5]  = mk(1,0,0,0,1,1,0,1, 32'h13,       32'h0,        8, 0,0, 32'h00000080);
    tbl[6]  = mk(1,0,0,0,1,1,1,0, 32'h12,       32'h0,        9, 0,0, 32'hFFFF80AD);
    tbl[7]  = mk(1,0,0,0,1,1,1,1, 32'h12,       32'h0,       10, 0,0, 32'h000080AD);
    tbl[8]  = mk(1,0,0,0,1,1,0,0, 32'h10,       32'h0,       11, 0,0, 32'hFFFFFFEF);
    tbl[9]  = mk(0,1,0,0,0,0,1,0, 32'h16,       32'h1234ABCD, 0, 0,0, 32'h0);
    tbl[10] = mk(1,0,0,0,1,1,1,0, 32'h16,       32'h0,       12, 0,0, 32'hFFFFABCD);
    tbl[11] = mk(1,0,0,0,1,1,2,0, 32'h410,      32'h0,       13, 0,0, 32'h80ADBEEF);
    tbl[12] = mk(1,1,0,0,0,0,2,0, 32'h20,       32'h11111111, 0, 0,0, 32'h0);
    tbl[13] = mk(1,0,0,0,1,1,2,0, 32'h20,       32'h0,       14, 0,0, 32'h11111111);
    tbl[14] = mk(0,0,1,1,0,0,2,0, 32'h0,        32'h0,        0, 1,0, 32'h0);
    tbl[15] = mk(0,0,1,0,0,0,2,0, 32'h4,        32'h0,        0, 0,0, 32'h0);
    tbl[16] = mk(0,0,0,0,1,0,2,0, 32'hCAFE0001, 32'h0,        7, 0,0, 32'h0);
    tbl[17] = mk(1,0,0,0,1,1,0,1, 32'h11,       32'h0,       15, 0,0, 32'h000000BE);

    tick(); tick();
    rst = 3'b000;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d stall", k), 32'(stall_out[k]), 32'd0);
      chk($sformatf("rst%0d pc_src", k), 32'(pc_src[k]), 32'd0);
      chk($sformatf("rst%0d misalign", k), 32'(misalign[k]), 32'd0);
      chk($sformatf("rst%0d ctl", k),
          32'({wb_valid[k], wb_reg_write[k], wb_mem_to_reg[k]}), 32'd0);
      chk($sformatf("rst%0d rdata", k), wb_read_data[k], 32'd0);
      chk($sformatf("rst%0d alu", k), wb_alu_result[k], 32'd0);
      chk($sformatf("rst%0d wreg", k), 32'(wb_write_reg[k]), 32'd0);
    end

    // Single-cycle vector table on instance 0.
    for (int i = 0; i < 18; i++) apply_vec(i, tbl[i]);

    // Bubble: valid/reg_write drop, data fields hold, no branch without valid.
    set_in(0, 1'b0, mk(0,0,1,1,1,0,2,0, 32'h99, 32'h0, 3, 0,0, 32'h0));
    #1;
    chk("bubble pc_src", 32'(pc_src[0]), 32'd0);
    tick();
    chk("bubble wb_valid", 32'(wb_valid[0]), 32'd0);
    chk("bubble reg_write", 32'(wb_reg_write[0]), 32'd0);
    chk("bubble alu hold", wb_alu_result[0], 32'h11);
    chk("bubble rdata hold", wb_read_data[0], 32'h000000BE);

`ifdef MEM_MISALIGN_CHECK_EN
    apply_vec(100, mk(0,1,0,0,1,0,2,0, 32'h11, 32'h55667788, 4, 0,1, 32'h0));
    apply_vec(101, mk(0,0,0,0,1,0,2,0, 32'h1234, 32'h0, 4, 0,0, 32'h0));
    apply_vec(102, mk(1,0,0,0,1,1,2,0, 32'h10, 32'h0, 4, 0,0, 32'h80ADBEEF));
    apply_vec(103, mk(1,0,0,0,1,1,1,0, 32'h13, 32'h0, 4, 0,1, 32'h0));
`else
    apply_vec(100, mk(0,1,0,0,0,0,2,0, 32'h11, 32'h55667788, 4, 0,0, 32'h0));
    apply_vec(101, mk(1,0,0,0,1,1,2,0, 32'h10, 32'h0, 4, 0,0, 32'h55667788));
    apply_vec(102, mk(1,0,0,0,1,1,1,0, 32'h13, 32'h0, 4, 0,0, 32'h00005566));
`endif
    set_in(0, 1'b0, nop);

    // WAIT_CYCLES=2: store then load, each stalling two cycles.
    run_mem("w2 sw", 1, mk(0,1,0,0,0,0,2,0, 32'h8, 32'hA5A5A5A5, 0, 0,0, 32'h0), 2);
    run_mem("w2 lw", 1, mk(1,0,0,0,1,1,2,0, 32'h8, 32'h0, 3, 0,0, 32'hA5A5A5A5), 2);
    set_in(1, 1'b1, mk(0,0,1,1,0,0,2,0, 32'h0, 32'h0, 0, 1,0, 32'h0));
    #1;
    chk("w2 br stall", 32'(stall_out[1]), 32'd0);
    chk("w2 br pc_src", 32'(pc_src[1]), 32'd1);
    tick();
    chk("w2 br wb_valid", 32'(wb_valid[1]), 32'd1);
    in_valid[1] = 1'b0;
    #1;
    chk("w2 br pc_src drop", 32'(pc_src[1]), 32'd0);

    // WAIT_CYCLES=3: reset during BUSY aborts a pending store.
    run_mem("w3 sw", 2, mk(0,1,0,0,0,0,2,0, 32'h20, 32'h12345678, 9, 0,0, 32'h0), 3);
    set_in(2, 1'b1, mk(0,1,0,0,1,1,2,0, 32'h20, 32'hFFFFFFFF, 9, 0,0, 32'h0));
    #1;
    chk("w3 abort stall0", 32'(stall_out[2]), 32'd1);
    tick();
    chk("w3 abort stall1", 32'(stall_out[2]), 32'd1);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    in_valid[2] = 1'b0;
    #1;
    chk("w3 rst stall", 32'(stall_out[2]), 32'd0);
    chk("w3 rst pc_src", 32'(pc_src[2]), 32'd0);
    chk("w3 rst ctl",
        32'({wb_valid[2], wb_reg_write[2], wb_mem_to_reg[2], misalign[2]}), 32'd0);
    chk("w3 rst alu", wb_alu_result[2], 32'd0);
    chk("w3 rst wreg", 32'(wb_write_reg[2]), 32'd0);
    chk("w3 rst rdata", wb_read_data[2], 32'd0);
    tick();
    run_mem("w3 lw", 2, mk(1,0,0,0,1,1,2,0, 32'h20, 32'h0, 2, 0,0, 32'h12345678), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
